// File: rtl/tube_sprite_renderer.sv
// Tube sprite renderer: 57x61 box hit test, sprite ROM addressing, transparency; optional mirror via TUBE_HFLIP_EN.
// Latency 3 cycles (stage 1, ROM/stage 2, output), one pixel per clock, never stalls.
module tube_sprite_renderer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  tube_x,
    input  logic [9:0]  tube_y,
    input  logic        tube_en,
    input  logic        flip_h,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [11:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        pixel_on,
    output logic [3:0]  palette_idx
);
    logic [9:0]  tx;
    logic [9:0]  ty;
    logic        en;
    logic        hit1;
    logic        hit2;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_box;
    logic [5:0]  dx;
    logic [5:0]  dy;
    logic [5:0]  col;
    logic [11:0] addr;

    // Position/enable are frame-stable: only a frame_start edge may change them.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tx <= '0;
            ty <= '0;
            en <= 1'b0;
        end else if (frame_start) begin
            tx <= tube_x;
            ty <= tube_y;
            en <= tube_en;
        end
    end

`ifdef TUBE_HFLIP_EN
    logic flip;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flip <= 1'b0;
        end else if (frame_start) begin
            flip <= flip_h;
        end
    end

    assign col = flip ? (6'd56 - dx) : dx;
`else
    logic unused_flip;

    assign unused_flip = flip_h;
    assign col         = dx;
`endif

    // 11-bit box edges so a sprite near the right/bottom border never wraps to column 0.
    always_comb begin
        x_end  = {1'b0, tx} + 11'd56;
        y_end  = {1'b0, ty} + 11'd60;
        in_box = (DrawX >= tx) && ({1'b0, DrawX} <= x_end) &&
                 (DrawY >= ty) && ({1'b0, DrawY} <= y_end);
        dx     = 6'(DrawX - tx);
        dy     = 6'(DrawY - ty);
        addr   = 12'(dy) * 12'd57 + 12'(col);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit1        <= 1'b0;
            rom_addr    <= '0;
            hit2        <= 1'b0;
            pixel_on    <= 1'b0;
            palette_idx <= '0;
        end else begin
            hit1        <= in_box && en;
            rom_addr    <= (in_box && en) ? addr : 12'd0;
            hit2        <= hit1;
            pixel_on    <= hit2 && (rom_data != 4'd0);
            palette_idx <= (hit2 && (rom_data != 4'd0)) ? rom_data : 4'd0;
        end
    end
endmodule

// File: tb/tb_tube_sprite_renderer.sv
// Bench for tube_sprite_renderer: registered ROM model plus a screen-level reference of the sprite box.
module tb_tube_sprite_renderer;
    logic        Clk;
    logic        Reset;
    logic        frame_start;
    logic [9:0]  tube_x;
    logic [9:0]  tube_y;
    logic        tube_en;
    logic        flip_h;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic        pixel_on;
    logic [3:0]  palette_idx;

    int checks;
    int failures;

    logic [3:0] rom [0:4095];

`ifdef TUBE_HFLIP_EN
    localparam bit HFLIP = 1'b1;
`else
    localparam bit HFLIP = 1'b0;
`endif

    // Reference model: latched sprite state and the outputs of the last three pixels.
    int       tx_m;
    int       ty_m;
    bit       en_m;
    bit       flip_m;
    bit       on_q [3];
    logic [3:0] pal_q [3];

    int       exp_addr;
    int       got_addr;
    bit       exp_on;
    bit       got_on;
    logic [3:0] exp_pal;
    logic [3:0] got_pal;

    tube_sprite_renderer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .tube_x      (tube_x),
        .tube_y      (tube_y),
        .tube_en     (tube_en),
        .flip_h      (flip_h),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_on    (pixel_on),
        .palette_idx (palette_idx)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) rom_data <= rom[rom_addr];

    task automatic clear_model();
        tx_m   = 0;
        ty_m   = 0;
        en_m   = 1'b0;
        flip_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            on_q[i]  = 1'b0;
            pal_q[i] = 4'd0;
        end
    endtask

    // Drive one pixel at a negedge, capture DUT outputs 1 time unit after the next posedge.
    task automatic cycle(input int x, input int y, input bit fs);
        int a;
        bit h;
        DrawX       = x[9:0];
        DrawY       = y[9:0];
        frame_start = fs;
        h = en_m && (x >= tx_m) && (x <= tx_m + 56) && (y >= ty_m) && (y <= ty_m + 60);
        a = 0;
        if (h) a = (y - ty_m) * 57 + (flip_m ? 56 - (x - tx_m) : x - tx_m);
        if (fs) begin
            tx_m   = int'(tube_x);
            ty_m   = int'(tube_y);
            en_m   = tube_en;
            flip_m = HFLIP ? flip_h : 1'b0;
        end
        on_q[2]  = on_q[1];
        pal_q[2] = pal_q[1];
        on_q[1]  = on_q[0];
        pal_q[1] = pal_q[0];
        on_q[0]  = h && (rom[a] != 4'd0);
        pal_q[0] = rom[a];
        exp_addr = a;
        exp_on   = on_q[2];
        exp_pal  = on_q[2] ? pal_q[2] : 4'd0;
        @(posedge Clk);
        #1;
        got_addr = int'(rom_addr);
        got_on   = pixel_on;
        got_pal  = palette_idx;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        frame_start = 1'b0;
        tube_x = 10'd0; tube_y = 10'd0; tube_en = 1'b0; flip_h = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        clear_model();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++; if (rom_addr !== 12'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (pixel_on !== 1'b0) begin failures++; $display("FAIL reset_pixel_on got=%0d exp=0", pixel_on); end
        checks++; if (palette_idx !== 4'd0) begin failures++; $display("FAIL reset_palette got=%0d exp=0", palette_idx); end
        Reset = 1'b0;
        tube_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(i, i, 1'b0);
            checks++; if (got_on !== 1'b0) begin failures++; $display("FAIL post_reset_dark got=%0d exp=0", got_on); end
            checks++; if (got_addr !== 0) begin failures++; $display("FAIL post_reset_addr got=%0d exp=0", got_addr); end
        end
    endtask

    task automatic test_basic();
        tube_x = 10'd100; tube_y = 10'd50; tube_en = 1'b1; flip_h = 1'b0;
        cycle(0, 0, 1'b1);
        cycle(100, 50, 1'b0);
        checks++; if (got_addr !== 0) begin failures++; $display("FAIL basic_origin_addr got=%0d exp=0", got_addr); end
        cycle(156, 110, 1'b0);
        checks++; if (got_addr !== 3476) begin failures++; $display("FAIL basic_last_addr got=%0d exp=3476", got_addr); end
        cycle(157, 110, 1'b0);
        checks++; if (got_addr !== 0) begin failures++; $display("FAIL basic_right_miss_addr got=%0d exp=0", got_addr); end
        checks++; if (got_on !== 1'b1) begin failures++; $display("FAIL basic_origin_on got=%0d exp=1", got_on); end
        checks++; if (got_pal !== 4'd5) begin failures++; $display("FAIL basic_origin_pal got=%0d exp=5", got_pal); end
        cycle(0, 0, 1'b0);
        checks++; if (got_on !== 1'b1 || got_pal !== 4'd9) begin failures++; $display("FAIL basic_last_pixel got=%0d/%0d exp=1/9", got_on, got_pal); end
        cycle(0, 0, 1'b0);
        checks++; if (got_on !== 1'b0) begin failures++; $display("FAIL basic_miss_on got=%0d exp=0", got_on); end
    endtask

    task automatic test_transparency();
        rom[3 * 57 + 4] = 4'd0;
        cycle(104, 53, 1'b0);
        checks++; if (got_addr !== 175) begin failures++; $display("FAIL transp_addr got=%0d exp=175", got_addr); end
        cycle(0, 0, 1'b0);
        cycle(0, 0, 1'b0);
        checks++; if (got_on !== 1'b0 || got_pal !== 4'd0) begin failures++; $display("FAIL transp_pixel got=%0d/%0d exp=0/0", got_on, got_pal); end
    endtask

    task automatic test_clip();
        int hits;
        tube_x = 10'd620; tube_y = 10'd50; tube_en = 1'b1; flip_h = 1'b0;
        cycle(0, 0, 1'b1);
        hits = 0;
        for (int x = 615; x < 640; x++) begin
            cycle(x, 60, 1'b0);
            if (got_addr != 0 || x == 620) hits++;
            checks++; if (got_addr !== exp_addr) begin failures++; $display("FAIL clip_x_addr x=%0d got=%0d exp=%0d", x, got_addr, exp_addr); end
            checks++; if (got_on !== exp_on) begin failures++; $display("FAIL clip_x_on x=%0d got=%0d exp=%0d", x, got_on, exp_on); end
        end
        checks++; if (hits !== 20) begin failures++; $display("FAIL clip_x_hit_count got=%0d exp=20", hits); end
        // Box extends past 1023: columns that would wrap to DrawX 0..32 must stay dark.
        tube_x = 10'd1000; tube_y = 10'd450;
        cycle(0, 0, 1'b1);
        for (int x = 0; x < 40; x++) begin
            cycle(x, 470, 1'b0);
            checks++; if (got_addr !== 0) begin failures++; $display("FAIL clip_wrap_addr x=%0d got=%0d exp=0", x, got_addr); end
        end
        for (int y = 470; y < 480; y++) begin
            cycle(1010, y, 1'b0);
            checks++; if (got_addr !== exp_addr) begin failures++; $display("FAIL clip_y_addr y=%0d got=%0d exp=%0d", y, got_addr, exp_addr); end
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 1'b0);
            checks++; if (got_on !== exp_on || got_pal !== exp_pal) begin failures++; $display("FAIL clip_flush got=%0d/%0d exp=%0d/%0d", got_on, got_pal, exp_on, exp_pal); end
        end
    endtask

    task automatic test_no_tearing();
        tube_x = 10'd100; tube_y = 10'd50; tube_en = 1'b1; flip_h = 1'b0;
        cycle(0, 0, 1'b1);
        tube_x = 10'd200;
        cycle(110, 50, 1'b0);
        checks++; if (got_addr !== 10) begin failures++; $display("FAIL tear_hold_old got=%0d exp=10", got_addr); end
        cycle(210, 50, 1'b0);
        checks++; if (got_addr !== 0) begin failures++; $display("FAIL tear_no_new got=%0d exp=0", got_addr); end
        cycle(110, 50, 1'b1);
        checks++; if (got_addr !== 10) begin failures++; $display("FAIL tear_fs_cycle_old got=%0d exp=10", got_addr); end
        cycle(210, 50, 1'b0);
        checks++; if (got_addr !== 10) begin failures++; $display("FAIL tear_moved got=%0d exp=10", got_addr); end
        cycle(110, 50, 1'b0);
        checks++; if (got_addr !== 0) begin failures++; $display("FAIL tear_old_gone got=%0d exp=0", got_addr); end
        for (int i = 0; i < 4; i++) rom[67 + i] = 4'hA;
        for (int i = 0; i < 4; i++) cycle(210 + i, 51, 1'b0);
        checks++; if (got_on !== 1'b1) begin failures++; $display("FAIL midline_pre_reset_on got=%0d exp=1", got_on); end
        #2;
        Reset = 1'b1;
        #1;
        checks++; if (pixel_on !== 1'b0 || palette_idx !== 4'd0) begin failures++; $display("FAIL midline_reset_now got=%0d/%0d exp=0/0", pixel_on, palette_idx); end
        checks++; if (rom_addr !== 12'd0) begin failures++; $display("FAIL midline_reset_addr got=%0d exp=0", rom_addr); end
        clear_model();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(210 + i, 51, 1'b0);
            checks++; if (got_on !== 1'b0) begin failures++; $display("FAIL midline_stay_dark got=%0d exp=0", got_on); end
        end
        cycle(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(210 + i, 51, 1'b0);
        checks++; if (got_on !== 1'b1 || got_pal !== 4'hA) begin failures++; $display("FAIL midline_relatch got=%0d/%0d exp=1/10", got_on, got_pal); end
    endtask

    task automatic test_hflip();
        tube_x = 10'd100; tube_y = 10'd50; tube_en = 1'b1; flip_h = 1'b1;
        cycle(0, 0, 1'b1);
        cycle(100, 50, 1'b0);
        checks++; if (got_addr !== (HFLIP ? 56 : 0)) begin failures++; $display("FAIL hflip_left got=%0d exp=%0d", got_addr, HFLIP ? 56 : 0); end
        cycle(156, 50, 1'b0);
        checks++; if (got_addr !== (HFLIP ? 0 : 56)) begin failures++; $display("FAIL hflip_right got=%0d exp=%0d", got_addr, HFLIP ? 0 : 56); end
        flip_h = 1'b0;
        cycle(0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        tube_y = 10'd100; tube_en = 1'b1; flip_h = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tube_x = 10'(300 + 10 * k);
            cycle(305, 100, 1'b1);
            checks++; if (got_addr !== exp_addr) begin failures++; $display("FAIL held_fs_addr k=%0d got=%0d exp=%0d", k, got_addr, exp_addr); end
        end
        cycle(330, 100, 1'b0);
        checks++; if (got_addr !== 10) begin failures++; $display("FAIL held_fs_final got=%0d exp=10", got_addr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit fs;
            int x;
            int y;
            fs = ($urandom_range(0, 24) == 0);
            if (fs) begin
                tube_x  = 10'($urandom_range(0, 1023));
                tube_y  = 10'($urandom_range(0, 1023));
                tube_en = ($urandom_range(0, 7) != 0);
                flip_h  = 1'($urandom_range(0, 1));
            end
            x = tx_m + int'($urandom_range(0, 70)) - 5;
            y = ty_m + int'($urandom_range(0, 74)) - 5;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            cycle(x, y, fs);
            checks++; if (got_addr !== exp_addr) begin failures++; $display("FAIL rand_addr i=%0d got=%0d exp=%0d", i, got_addr, exp_addr); end
            checks++; if (got_on !== exp_on || got_pal !== exp_pal) begin failures++; $display("FAIL rand_pixel i=%0d got=%0d/%0d exp=%0d/%0d", i, got_on, got_pal, exp_on, exp_pal); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 4'($urandom_range(0, 15));
        rom[0]    = 4'd5;
        rom[3476] = 4'd9;
        Reset = 1'b1;
        @(negedge Clk);
        test_reset();
        test_basic();
        test_transparency();
        test_clip();
        test_no_tearing();
        test_hflip();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
